// File: rtl/mpsoc_dbg_pkg.sv
// Shared definitions for the debug SPR responder: FSM states, debug SPR group
// number and local register indices.
package mpsoc_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_ACK  = 2'd2,
    ST_HOLD = 2'd3
  } spr_state_e;

  localparam logic [4:0]  SPR_GRP_DBG    = 5'd6;
  localparam logic [10:0] SPR_IDX_DMR1   = 11'h010;
  localparam logic [10:0] SPR_IDX_DMR2   = 11'h011;
  localparam logic [10:0] SPR_IDX_DSR    = 11'h014;
  localparam logic [10:0] SPR_IDX_DRR    = 11'h015;
  localparam logic [10:0] SPR_IDX_DSTAT  = 11'h01F;

  // SPR group lives in address bits [15:11].
  function automatic logic is_dbg_spr(input logic [15:0] addr);
    return addr[15:11] == SPR_GRP_DBG;
  endfunction

endpackage

// File: rtl/mpsoc_dbg_spr_responder_if.sv
// Debug BIU <-> SPR responder request/acknowledge bus. Signal names are seen
// from the responder side.
interface mpsoc_dbg_spr_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [DATA_W-1:0] cpu_data_i;
  logic [DATA_W-1:0] cpu_data_o;
  logic              cpu_stb_i;
  logic              cpu_we_i;
  logic              cpu_ack_o;

  modport master (
    output cpu_addr_i, cpu_data_i, cpu_stb_i, cpu_we_i,
    input  cpu_data_o, cpu_ack_o
  );

  modport slave (
    input  cpu_addr_i, cpu_data_i, cpu_stb_i, cpu_we_i,
    output cpu_data_o, cpu_ack_o
  );
endinterface

// File: rtl/mpsoc_dbg_spr_regs.sv
// Local debug-group SPRs (DMR1, DMR2, DSR, DRR, DSTAT) and stall generation.
// DSTAT[0] exists only when MPSOC_DBG_SPR_TIMEOUT_EN is defined.
module mpsoc_dbg_spr_regs
  import mpsoc_dbg_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int EXC_WIDTH = 14
) (
  input  logic                 cpu_clk_i,
  input  logic                 cpu_rstn_i,
  input  logic                 wr_en,
  input  logic [10:0]          idx,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata,
`ifdef MPSOC_DBG_SPR_TIMEOUT_EN
  input  logic                 timeout_set,
`endif
  input  logic [EXC_WIDTH-1:0] exc_i,
  output logic                 dbg_stall_o
);

  logic [DATA_W-1:0]    dmr1, dmr2;
  logic [EXC_WIDTH-1:0] dsr, drr, drr_next;

  // Set beats write: the exception OR is applied after the write value.
  always_comb begin
    // NOTE: default assignment first so every path drives drr_next and no latch is inferred.
    drr_next = drr;
    if (wr_en && idx == SPR_IDX_DRR) drr_next = wdata[EXC_WIDTH-1:0];
    drr_next = drr_next | (exc_i & dsr);
  end

  always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
    if (!cpu_rstn_i) begin
      dmr1        <= '0;
      dmr2        <= '0;
      dsr         <= '0;
      drr         <= '0;
      dbg_stall_o <= 1'b0;
    end else begin
      if (wr_en) begin
        case (idx)
          SPR_IDX_DMR1: dmr1 <= wdata;
          SPR_IDX_DMR2: dmr2 <= wdata;
          SPR_IDX_DSR:  dsr  <= wdata[EXC_WIDTH-1:0];
          default:      ;
        endcase
      end
      drr         <= drr_next;
      dbg_stall_o <= |drr_next;
    end
  end

`ifdef MPSOC_DBG_SPR_TIMEOUT_EN
  logic dstat_to;

  always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
    if (!cpu_rstn_i)                                     dstat_to <= 1'b0;
    else if (timeout_set)                                dstat_to <= 1'b1;
    else if (wr_en && idx == SPR_IDX_DSTAT && wdata[0])  dstat_to <= 1'b0;
  end
`endif

  always_comb begin
    rdata = '0;
    case (idx)
      SPR_IDX_DMR1:  rdata = dmr1;
      SPR_IDX_DMR2:  rdata = dmr2;
      SPR_IDX_DSR:   rdata[EXC_WIDTH-1:0] = dsr;
      SPR_IDX_DRR:   rdata[EXC_WIDTH-1:0] = drr;
`ifdef MPSOC_DBG_SPR_TIMEOUT_EN
      SPR_IDX_DSTAT: rdata[0] = dstat_to;
`endif
      default:       ;
    endcase
  end

endmodule

// File: rtl/mpsoc_dbg_spr_responder.sv
// Debug SPR responder: serves debug-group SPRs locally, forwards the rest to
// the core. Optional forward timeout via MPSOC_DBG_SPR_TIMEOUT_EN.
module mpsoc_dbg_spr_responder
  import mpsoc_dbg_pkg::*;
#(
  parameter int CPU_ADDR_WIDTH = 32,
  parameter int CPU_DATA_WIDTH = 32,
  parameter int EXC_WIDTH      = 14,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      cpu_clk_i,
  input  logic                      cpu_rstn_i,
  mpsoc_dbg_spr_responder_if.slave  dbg_bus,
  output logic                      spr_req_o,
  output logic                      spr_we_o,
  output logic [CPU_ADDR_WIDTH-1:0] spr_addr_o,
  output logic [CPU_DATA_WIDTH-1:0] spr_wdata_o,
  input  logic [CPU_DATA_WIDTH-1:0] spr_rdata_i,
  input  logic                      spr_gnt_i,
  input  logic [EXC_WIDTH-1:0]      exc_i,
  output logic                      dbg_stall_o
);

  spr_state_e          state;
  logic                req_local, local_wr;
  logic [CPU_DATA_WIDTH-1:0] local_rdata;

  assign req_local = dbg_bus.cpu_stb_i && is_dbg_spr(dbg_bus.cpu_addr_i[15:0]);
  assign local_wr  = (state == ST_IDLE) && req_local && dbg_bus.cpu_we_i;

`ifdef MPSOC_DBG_SPR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] fwd_cnt;
  logic             timeout_hit;

  assign timeout_hit = (state == ST_FWD) && !spr_gnt_i &&
                       (fwd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  mpsoc_dbg_spr_regs #(
    .DATA_W    (CPU_DATA_WIDTH),
    .EXC_WIDTH (EXC_WIDTH)
  ) u_regs (
    .cpu_clk_i   (cpu_clk_i),
    .cpu_rstn_i  (cpu_rstn_i),
    .wr_en       (local_wr),
    .idx         (dbg_bus.cpu_addr_i[10:0]),
    .wdata       (dbg_bus.cpu_data_i),
    .rdata       (local_rdata),
`ifdef MPSOC_DBG_SPR_TIMEOUT_EN
    .timeout_set (timeout_hit),
`endif
    .exc_i       (exc_i),
    .dbg_stall_o (dbg_stall_o)
  );

  // The spr_* output registers double as the latched request; they are only
  // non-zero while in FWD.
  always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
    // NOTE: clocked state uses non-blocking assignments only, so all flops update together.
    if (!cpu_rstn_i) begin
      state              <= ST_IDLE;
      dbg_bus.cpu_ack_o  <= 1'b0;
      dbg_bus.cpu_data_o <= '0;
      spr_req_o          <= 1'b0;
      spr_we_o           <= 1'b0;
      spr_addr_o         <= '0;
      spr_wdata_o        <= '0;
`ifdef MPSOC_DBG_SPR_TIMEOUT_EN
      fwd_cnt            <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_local) begin
            state              <= ST_ACK;
            dbg_bus.cpu_ack_o  <= 1'b1;
            dbg_bus.cpu_data_o <= dbg_bus.cpu_we_i ? '0 : local_rdata;
          end else if (dbg_bus.cpu_stb_i) begin
            state       <= ST_FWD;
            spr_req_o   <= 1'b1;
            spr_we_o    <= dbg_bus.cpu_we_i;
            spr_addr_o  <= dbg_bus.cpu_addr_i;
            spr_wdata_o <= dbg_bus.cpu_data_i;
`ifdef MPSOC_DBG_SPR_TIMEOUT_EN
            fwd_cnt     <= '0;
`endif
          end
        end
        ST_FWD: begin
          if (spr_gnt_i) begin
            state              <= ST_ACK;
            dbg_bus.cpu_ack_o  <= 1'b1;
            dbg_bus.cpu_data_o <= spr_rdata_i;
            spr_req_o          <= 1'b0;
            spr_we_o           <= 1'b0;
            spr_addr_o         <= '0;
            spr_wdata_o        <= '0;
          end
`ifdef MPSOC_DBG_SPR_TIMEOUT_EN
          else if (timeout_hit) begin
            state              <= ST_ACK;
            dbg_bus.cpu_ack_o  <= 1'b1;
            dbg_bus.cpu_data_o <= '0;
            spr_req_o          <= 1'b0;
            spr_we_o           <= 1'b0;
            spr_addr_o         <= '0;
            spr_wdata_o        <= '0;
          end else begin
            fwd_cnt <= fwd_cnt + 1'b1;
          end
`endif
        end
        ST_ACK: begin
          state              <= ST_HOLD;
          dbg_bus.cpu_ack_o  <= 1'b0;
          dbg_bus.cpu_data_o <= '0;
        end
        // HOLD ignores a lingering strobe so each request gets exactly one ack.
        ST_HOLD: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpsoc_dbg_spr_responder.sv
// Scoreboard bench for mpsoc_dbg_spr_responder; covers the timeout path when
// built with MPSOC_DBG_SPR_TIMEOUT_EN.
module tb_mpsoc_dbg_spr_responder;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int EW = 14;
  localparam int TO = 16;

  logic          cpu_clk_i = 1'b0;
  logic          cpu_rstn_i = 1'b0;
  logic          spr_req_o, spr_we_o, dbg_stall_o;
  logic [AW-1:0] spr_addr_o;
  logic [DW-1:0] spr_wdata_o;
  logic [DW-1:0] spr_rdata_i = '0;
  logic          spr_gnt_i = 1'b0;
  logic [EW-1:0] exc_i = '0;

  always #5 cpu_clk_i = ~cpu_clk_i;

  mpsoc_dbg_spr_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mpsoc_dbg_spr_responder #(
    .CPU_ADDR_WIDTH (AW),
    .CPU_DATA_WIDTH (DW),
    .EXC_WIDTH      (EW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .cpu_clk_i   (cpu_clk_i),
    .cpu_rstn_i  (cpu_rstn_i),
    .dbg_bus     (bus),
    .spr_req_o   (spr_req_o),
    .spr_we_o    (spr_we_o),
    .spr_addr_o  (spr_addr_o),
    .spr_wdata_o (spr_wdata_o),
    .spr_rdata_i (spr_rdata_i),
    .spr_gnt_i   (spr_gnt_i),
    .exc_i       (exc_i),
    .dbg_stall_o (dbg_stall_o)
  );

  typedef struct {
    string       tag;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          ack_count = 0;
  int          gnt_delay = 1;
  bit          gnt_never = 1'b0;
  logic [31:0] core_rdata = '0;
  int          req_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Core model: grants after gnt_delay cycles of visible request.
  always @(negedge cpu_clk_i) begin
    if (spr_req_o === 1'b1 && !gnt_never) begin
      req_cnt++;
      spr_gnt_i   = (req_cnt >= gnt_delay);
      spr_rdata_i = spr_gnt_i ? core_rdata : '0;
    end else begin
      req_cnt     = 0;
      spr_gnt_i   = 1'b0;
      spr_rdata_i = '0;
    end
  end

  // Every ack pops one expected read value; an ack with nothing queued is an error.
  always @(negedge cpu_clk_i) begin
    exp_t e;
    if (bus.cpu_ack_o === 1'b1) begin
      ack_count++;
      if (sb_q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check({e.tag, "_data"}, bus.cpu_data_o, e.data);
      end
    end
  end

  task automatic access(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_data,
                        input int exp_lat, input int exp_req,
                        input logic [EW-1:0] exc_pulse, input bit linger);
    int   lat = 0;
    int   req_cycles = 0;
    int   acks_before;
    bit   acked = 1'b0;
    exp_t e;
    e.tag  = tag;
    e.data = exp_data;
    sb_q.push_back(e);
    @(negedge cpu_clk_i);
    acks_before    = ack_count;
    bus.cpu_stb_i  = 1'b1;
    bus.cpu_we_i   = we;
    bus.cpu_addr_i = addr;
    bus.cpu_data_i = wdata;
    exc_i          = exc_pulse;
    for (int i = 0; i < 100 && !acked; i++) begin
      @(negedge cpu_clk_i);
      exc_i = '0;
      lat++;
      if (spr_req_o === 1'b1) begin
        if (req_cycles == 0) begin
          check({tag, "_spr_addr"}, spr_addr_o, addr);
          check({tag, "_spr_we"}, 32'(spr_we_o), 32'(we));
          check({tag, "_spr_wdata"}, spr_wdata_o, wdata);
        end
        req_cycles++;
      end
      if (bus.cpu_ack_o === 1'b1) acked = 1'b1;
    end
    if (!acked) begin
      check({tag, "_ack_seen"}, 32'd0, 32'd1);
      void'(sb_q.pop_back());
    end else begin
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_req_cycles"}, 32'(req_cycles), 32'(exp_req));
    end
    if (linger) begin
      @(negedge cpu_clk_i);
      @(negedge cpu_clk_i);
    end
    bus.cpu_stb_i  = 1'b0;
    bus.cpu_we_i   = 1'b0;
    bus.cpu_addr_i = '0;
    bus.cpu_data_i = '0;
    if (linger) begin
      @(negedge cpu_clk_i);
      @(negedge cpu_clk_i);
      check({tag, "_ack_count"}, 32'(ack_count - acks_before), 32'd1);
    end
    @(negedge cpu_clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int acks_before;
    bus.cpu_stb_i  = 1'b0;
    bus.cpu_we_i   = 1'b0;
    bus.cpu_addr_i = '0;
    bus.cpu_data_i = '0;
    repeat (3) @(negedge cpu_clk_i);
    check("rst_ack", 32'(bus.cpu_ack_o), 32'd0);
    check("rst_data", bus.cpu_data_o, 32'd0);
    check("rst_req", 32'(spr_req_o), 32'd0);
    check("rst_we", 32'(spr_we_o), 32'd0);
    check("rst_addr", spr_addr_o, 32'd0);
    check("rst_wdata", spr_wdata_o, 32'd0);
    check("rst_stall", 32'(dbg_stall_o), 32'd0);
    cpu_rstn_i = 1'b1;
    @(negedge cpu_clk_i);

    // Local registers
    access("dsr_wr",   1, 32'h3014, 32'h0000_0008, 32'h0, 1, 0, '0, 0);
    access("dsr_rd",   0, 32'h3014, 32'h0,         32'h0000_0008, 1, 0, '0, 0);
    access("dmr1_wr",  1, 32'h3010, 32'hDEAD_BEEF, 32'h0, 1, 0, '0, 0);
    access("dmr1_rd",  0, 32'h3010, 32'h0,         32'hDEAD_BEEF, 1, 0, '0, 0);
    access("dmr2_wr",  1, 32'h3011, 32'h1234_5678, 32'h0, 1, 0, '0, 0);
    access("dmr2_rd",  0, 32'h3011, 32'h0,         32'h1234_5678, 1, 0, '0, 0);
    access("unmap_wr", 1, 32'h3012, 32'hFFFF_FFFF, 32'h0, 1, 0, '0, 0);
    access("unmap_rd", 0, 32'h3012, 32'h0,         32'h0, 1, 0, '0, 0);
    check("stall_idle", 32'(dbg_stall_o), 32'd0);

    // Exception capture: only bit 3 is enabled in DSR
    @(negedge cpu_clk_i);
    exc_i = 14'h000C;
    @(negedge cpu_clk_i);
    exc_i = '0;
    check("stall_after_exc", 32'(dbg_stall_o), 32'd1);
    access("drr_rd",      0, 32'h3015, 32'h0, 32'h0000_0008, 1, 0, '0, 0);
    access("drr_wr_set",  1, 32'h3015, 32'h0, 32'h0, 1, 0, 14'h0008, 0);
    access("drr_rd_set",  0, 32'h3015, 32'h0, 32'h0000_0008, 1, 0, '0, 0);
    access("drr_clr",     1, 32'h3015, 32'h0, 32'h0, 1, 0, '0, 0);
    check("stall_cleared", 32'(dbg_stall_o), 32'd0);
    access("drr_rd_clr",  0, 32'h3015, 32'h0, 32'h0, 1, 0, '0, 0);
    access("drr_wr_all",  1, 32'h3015, 32'hFFFF_FFFF, 32'h0, 1, 0, '0, 0);
    check("stall_wr_all", 32'(dbg_stall_o), 32'd1);
    access("drr_rd_all",  0, 32'h3015, 32'h0, 32'h0000_3FFF, 1, 0, '0, 0);
    access("drr_clr2",    1, 32'h3015, 32'h0, 32'h0, 1, 0, '0, 0);

    // Forwarded accesses
    gnt_delay = 5; core_rdata = 32'hCAFE_F00D;
    access("fwd_rd", 0, 32'h0000_2801, 32'h0, 32'hCAFE_F00D, 6, 5, '0, 0);
    gnt_delay = 1; core_rdata = 32'h0;
    access("fwd_wr", 1, 32'h0000_1234, 32'hA5A5_5A5A, 32'h0, 2, 1, '0, 0);

    // Strobe lingering through ACK and HOLD
    access("linger_rd", 0, 32'h3010, 32'h0, 32'hDEAD_BEEF, 1, 0, '0, 1);

`ifdef MPSOC_DBG_SPR_TIMEOUT_EN
    gnt_never = 1'b1;
    access("timeout_rd", 0, 32'h0000_0100, 32'h0, 32'h0, TO + 1, TO, '0, 0);
    gnt_never = 1'b0;
    access("dstat_rd_set", 0, 32'h301F, 32'h0, 32'h0000_0001, 1, 0, '0, 0);
    access("dstat_w1c",    1, 32'h301F, 32'h1, 32'h0, 1, 0, '0, 0);
    access("dstat_rd_clr", 0, 32'h301F, 32'h0, 32'h0, 1, 0, '0, 0);
`else
    access("dstat_rd", 0, 32'h301F, 32'h0, 32'h0, 1, 0, '0, 0);
    gnt_delay = 20; core_rdata = 32'h1234_5678;
    access("slow_fwd", 0, 32'h0000_0100, 32'h0, 32'h1234_5678, 21, 20, '0, 0);
`endif

    // Reset during FWD aborts the access without an ack
    access("pre_rst_dsr",  1, 32'h3014, 32'h0000_0008, 32'h0, 1, 0, '0, 0);
    access("pre_rst_drr",  1, 32'h3015, 32'h0000_0001, 32'h0, 1, 0, '0, 0);
    gnt_never = 1'b1;
    @(negedge cpu_clk_i);
    acks_before    = ack_count;
    bus.cpu_stb_i  = 1'b1;
    bus.cpu_we_i   = 1'b0;
    bus.cpu_addr_i = 32'h0000_2801;
    repeat (3) @(negedge cpu_clk_i);
    check("mid_fwd_req", 32'(spr_req_o), 32'd1);
    check("mid_fwd_stall", 32'(dbg_stall_o), 32'd1);
    #2 cpu_rstn_i = 1'b0;
    #1;
    check("abort_req", 32'(spr_req_o), 32'd0);
    check("abort_addr", spr_addr_o, 32'd0);
    check("abort_ack", 32'(bus.cpu_ack_o), 32'd0);
    check("abort_stall", 32'(dbg_stall_o), 32'd0);
    @(negedge cpu_clk_i);
    bus.cpu_stb_i  = 1'b0;
    bus.cpu_addr_i = '0;
    @(negedge cpu_clk_i);
    cpu_rstn_i = 1'b1;
    repeat (10) @(negedge cpu_clk_i);
    check("abort_no_ack", 32'(ack_count - acks_before), 32'd0);
    gnt_never = 1'b0;
    access("post_rst_dsr",  0, 32'h3014, 32'h0, 32'h0, 1, 0, '0, 0);
    access("post_rst_drr",  0, 32'h3015, 32'h0, 32'h0, 1, 0, '0, 0);
    access("post_rst_dmr1", 0, 32'h3010, 32'h0, 32'h0, 1, 0, '0, 0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
